mmio_console: RTL

//  Data-port decoder between steel_core_top's data bus and the shared mem block in the simulation top.

---
 rtl/mmio_pkg.sv | 30 +++
 rtl/mmio_console_if.sv | 27 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mmio_console.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO console window: register addresses, status
// bit positions, the tohost write mask and the decode-select type.
package mmio_pkg;

    localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0001_0000;
    localparam logic [31:0] STATUS_ADDR_DEF  = 32'h0001_0004;
    localparam logic [31:0] TOHOST_ADDR_DEF  = 32'h0001_0008;
    localparam int          FIFO_DEPTH_DEF   = 16;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 8;

    // tohost only takes effect on a full-word store
    localparam logic [3:0] TOHOST_MASK = 4'hF;

    typedef enum logic [1:0] {
        SEL_MEM,
        SEL_CONSOLE,
        SEL_STATUS,
        SEL_TOHOST
    } mmio_sel_e;

    // Word-granular address compare; byte offset bits are ignored.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// Core data-port bus as seen by the MMIO decoder. The core side is the
// master (drives address/data/strobes), the decoder is the slave.
interface mmio_console_if;

    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        wr_en;
    logic [3:0]  wr_mask;
    logic [31:0] d_rdata;

    modport master (
        output d_addr,
        output d_wdata,
        output wr_en,
        output wr_mask,
        input  d_rdata
    );

    modport slave (
        input  d_addr,
        input  d_wdata,
        input  wr_en,
        input  wr_mask,
        output d_rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head (no fall-through). Data written
// into an empty FIFO becomes visible on o_data one cycle later together
// with !o_empty. A push while full is accepted only if a pop happens in
// the same cycle, so occupancy never exceeds DEPTH.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Head is forced to zero while empty so stale storage never leaks out.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mmio_console.sv
// Data-port decoder sitting between the core and the shared memory.
// Three word addresses form an MMIO window: a write-only console byte
// register feeding a TX FIFO, a read-only status register, and a
// write-only tohost register that latches a sticky halt plus exit code.
// Everything else passes through to memory. Read data is steered one
// cycle after the address to line up with the memory's read latency.
module mmio_console
    import mmio_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF,
    parameter logic [31:0] TOHOST_ADDR  = TOHOST_ADDR_DEF,
    parameter int          FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mmio_console_if.slave        bus,
    output logic                 o_mem_wr_en,
    input  logic [31:0]          i_mem_rdata,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_halt,
    output logic [31:0]          o_exit_code
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mmio_sel_e   w_sel;
    logic        w_hit;
    logic        w_push_req;
    logic        w_push_ok;
    logic        w_pop;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic [31:0] w_status;
    logic        w_tohost_wr;
    logic        w_unused_addr_lsb;

    logic        r_sel_q;
    logic [31:0] r_mmio_q;
    logic        r_overflow;
    logic        r_halt;
    logic [31:0] r_exit_code;

    // Address decode into one of the window registers or plain memory.
    always_comb begin
        w_sel = SEL_MEM;
        if (word_match(bus.d_addr, CONSOLE_ADDR)) begin
            w_sel = SEL_CONSOLE;
        end else if (word_match(bus.d_addr, STATUS_ADDR)) begin
            w_sel = SEL_STATUS;
        end else if (word_match(bus.d_addr, TOHOST_ADDR)) begin
            w_sel = SEL_TOHOST;
        end
    end

    assign w_hit             = (w_sel != SEL_MEM);
    assign w_unused_addr_lsb = &{1'b0, bus.d_addr[1:0]};

    // MMIO stores are swallowed here; memory only sees non-window writes.
    assign o_mem_wr_en = bus.wr_en & ~w_hit;

    // Console push uses byte lane 0 only; upper lanes are ignored.
    assign w_push_req = bus.wr_en && (w_sel == SEL_CONSOLE) && bus.wr_mask[0];
    assign w_pop      = o_tx_valid && i_tx_ready;
    assign w_push_ok  = w_push_req && (!w_fifo_full || w_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push_ok),
        .i_data  (bus.d_wdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (o_tx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign o_tx_valid = !w_fifo_empty;

    // Status word built from the current (pre-update) FIFO state.
    always_comb begin
        w_status                               = '0;
        w_status[STATUS_EMPTY_BIT]             = w_fifo_empty;
        w_status[STATUS_FULL_BIT]              = w_fifo_full;
        w_status[STATUS_OVF_BIT]               = r_overflow;
        w_status[STATUS_COUNT_LSB +: 8]        = 8'(w_fifo_count);
    end

    // Read-side select and MMIO data registered to match memory read latency.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_q  <= 1'b0;
            r_mmio_q <= '0;
        end else begin
            r_sel_q  <= w_hit;
            r_mmio_q <= (w_sel == SEL_STATUS) ? w_status : 32'h0;
        end
    end

    assign bus.d_rdata = r_sel_q ? r_mmio_q : i_mem_rdata;

    // Sticky overflow: a console byte arrived with no room and no pop to make room.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push_ok) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_tohost_wr = bus.wr_en && (w_sel == SEL_TOHOST) && (bus.wr_mask == TOHOST_MASK);

    // First full-word tohost store wins; later ones cannot rewrite the exit code.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_halt      <= 1'b0;
            r_exit_code <= '0;
        end else if (w_tohost_wr && !r_halt) begin
            r_halt      <= 1'b1;
            r_exit_code <= bus.d_wdata;
        end
    end

    assign o_halt      = r_halt;
    assign o_exit_code = r_exit_code;

endmodule
